// File: rtl/frame_config_writer.sv
// Frame-latch config writer: sync/header/data stream to FrameData + one-hot FrameStrobe (CONFIG_CHECKSUM_EN adds a sum trailer check).
// Latency: data accept -> 1 setup cycle -> 1 strobe cycle -> 1 hold cycle; one frame per 4 cycles.
// Backpressure: s_ready is low during SETUP/STROBE/HOLD and during reset; waits indefinitely for s_valid.
module frame_config_writer #(
    parameter int                         FrameBitsPerRow = 32,
    parameter int                         MaxFramesPerCol = 20,
    parameter logic [FrameBitsPerRow-1:0] SyncWord        = 'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       err_clr
);

    typedef enum logic [2:0] {
        HUNT, HEADER, DWAIT, SETUP, STROBE, HOLD
`ifdef CONFIG_CHECKSUM_EN
        , CHECK
`endif
    } state_t;

    localparam logic [8:0] MaxFrames9 = 9'(MaxFramesPerCol);

    state_t                       state, nextState;
    logic [7:0]                   frameIdx, nextIdx;
    logic [7:0]                   frameCnt, nextCnt;
    logic [FrameBitsPerRow-1:0]   dataNext;
    logic [MaxFramesPerCol-1:0]   strobeNext;
    logic                         doneNext;
    logic                         errSet;
    logic                         rstDone;
    logic                         accept;
    logic [8:0]                   hdrIdx9;
    logic [8:0]                   hdrEnd9;
`ifdef CONFIG_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0]   sum, sumNext;
`endif

    // rstDone keeps s_ready low while reset is asserted even though state already reads HUNT
    assign s_ready = rstDone && (state == HUNT || state == HEADER || state == DWAIT
`ifdef CONFIG_CHECKSUM_EN
                                 || state == CHECK
`endif
                                );
    assign accept  = s_valid && s_ready;
    assign busy    = (state != HUNT);
    assign hdrIdx9 = {1'b0, s_data[7:0]};
    assign hdrEnd9 = hdrIdx9 + {1'b0, s_data[15:8]};

    always_comb begin
        nextState  = state;
        nextIdx    = frameIdx;
        nextCnt    = frameCnt;
        dataNext   = FrameData;
        strobeNext = '0;
        doneNext   = 1'b0;
        errSet     = 1'b0;
`ifdef CONFIG_CHECKSUM_EN
        sumNext    = sum;
`endif
        case (state)
            HUNT: begin
                if (accept && s_data == SyncWord) nextState = HEADER;
            end
            HEADER: begin
                if (accept) begin
`ifdef CONFIG_CHECKSUM_EN
                    sumNext = '0;
`endif
                    if (s_data[15:8] == 8'd0) begin
                        nextState = HUNT;
                    end else if (hdrIdx9 >= MaxFrames9 || hdrEnd9 > MaxFrames9) begin
                        errSet    = 1'b1;
                        nextState = HUNT;
                    end else begin
                        nextIdx   = s_data[7:0];
                        nextCnt   = s_data[15:8];
                        nextState = DWAIT;
                    end
                end
            end
            DWAIT: begin
                if (accept) begin
                    dataNext  = s_data;
`ifdef CONFIG_CHECKSUM_EN
                    sumNext   = sum + s_data;
`endif
                    nextState = SETUP;
                end
            end
            SETUP: begin
                // strobe is loaded here so it leaves a flop aligned with STROBE
                for (int i = 0; i < MaxFramesPerCol; i++) strobeNext[i] = (frameIdx == 8'(i));
                nextState = STROBE;
            end
            STROBE: nextState = HOLD;
            HOLD: begin
                nextIdx = frameIdx + 8'd1;
                nextCnt = frameCnt - 8'd1;
                if (frameCnt != 8'd1) begin
                    nextState = DWAIT;
                end else begin
`ifdef CONFIG_CHECKSUM_EN
                    nextState = CHECK;
`else
                    doneNext  = 1'b1;
                    nextState = HUNT;
`endif
                end
            end
`ifdef CONFIG_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (s_data == sum) doneNext = 1'b1;
                    else               errSet   = 1'b1;
                    nextState = HUNT;
                end
            end
`endif
            default: nextState = HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state       <= HUNT;
            frameIdx    <= '0;
            frameCnt    <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            rstDone     <= 1'b0;
`ifdef CONFIG_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            state       <= nextState;
            frameIdx    <= nextIdx;
            frameCnt    <= nextCnt;
            FrameData   <= dataNext;
            FrameStrobe <= strobeNext;
            done        <= doneNext;
            // a new error outranks a simultaneous clear
            err         <= errSet | (err & ~err_clr);
            rstDone     <= 1'b1;
`ifdef CONFIG_CHECKSUM_EN
            sum         <= sumNext;
`endif
        end
    end

endmodule

// File: tb/tb_frame_config_writer.sv
// Bench for frame_config_writer: packet-level reference model compared every cycle, plus directed literal checks.
module tb_frame_config_writer;

    localparam int          NF   = 20;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
    localparam int PH_SYNC = 0, PH_HDR = 1, PH_DATA = 2, PH_TRAIL = 3;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   FrameData;
    logic [NF-1:0] FrameStrobe;
    logic          busy, done, err;
    logic          err_clr = 1'b0;

    frame_config_writer #(.FrameBitsPerRow(32), .MaxFramesPerCol(NF), .SyncWord(SYNC)) dut (
        .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .FrameData(FrameData), .FrameStrobe(FrameStrobe), .busy(busy), .done(done),
        .err(err), .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    int vectors = 0, miscompares = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: packet phase, queue of frame indices still to write, and a
    // countdown of the three fixed cycles (setup/strobe/hold) following each data accept.
    int          mPhase = PH_SYNC, mBlack = 0, mCur = 0, hi, hc;
    int          mIdxQ[$];
    logic [31:0] mData = '0, mSum = '0;
    bit          mErr = 0, mDone = 0, mArmed = 0, mAcc;

    always @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            mPhase = PH_SYNC; mBlack = 0; mCur = 0; mData = '0; mSum = '0;
            mErr = 0; mDone = 0; mArmed = 0; mIdxQ.delete();
        end else begin
            mAcc  = s_valid && mArmed && (mBlack == 0);
            mDone = 0;
            if (err_clr) mErr = 0;
            if (mBlack != 0) begin
                mBlack--;
                if (mBlack == 0 && mIdxQ.size() == 0) begin
`ifdef CONFIG_CHECKSUM_EN
                    mPhase = PH_TRAIL;
`else
                    mPhase = PH_SYNC;
                    mDone  = 1;
`endif
                end
            end else if (mAcc) begin
                case (mPhase)
                    PH_SYNC: if (s_data == SYNC) mPhase = PH_HDR;
                    PH_HDR: begin
                        hi = int'(s_data[7:0]);
                        hc = int'(s_data[15:8]);
                        if (hc == 0) mPhase = PH_SYNC;
                        else if (hi >= NF || hi + hc > NF) begin mErr = 1; mPhase = PH_SYNC; end
                        else begin
                            for (int k = 0; k < hc; k++) mIdxQ.push_back(hi + k);
                            mSum = '0;
                            mPhase = PH_DATA;
                        end
                    end
                    PH_DATA: begin
                        mData = s_data;
                        mSum  = mSum + s_data;
                        mCur  = mIdxQ.pop_front();
                        mBlack = 3;
                    end
                    default: begin
                        if (s_data == mSum) mDone = 1; else mErr = 1;
                        mPhase = PH_SYNC;
                    end
                endcase
            end
            mArmed = 1;
        end
    end

    typedef struct { int c; logic [NF-1:0] m; logic [31:0] d; } sev_t;
    sev_t          strobeLog[$];
    bit            readyLog[int];
    int            dataCyc = 0, doneCnt = 0, doneCyc = 0;
    logic [31:0]   lastData = '0;
    logic [NF-1:0] one = 1, expStrobe;

    always @(negedge CLK) begin
        cyc++;
        expStrobe = (mBlack == 2) ? (one << mCur) : '0;
        chk("s_ready",     64'(s_ready),     64'(mArmed && mBlack == 0));
        chk("busy",        64'(busy),        64'(mPhase != PH_SYNC));
        chk("done",        64'(done),        64'(mDone));
        chk("err",         64'(err),         64'(mErr));
        chk("FrameStrobe", 64'(FrameStrobe), 64'(expStrobe));
        chk("FrameData",   64'(FrameData),   64'(mData));
        readyLog[cyc] = s_ready;
        if (FrameStrobe != '0) strobeLog.push_back('{cyc, FrameStrobe, FrameData});
        if (FrameData != lastData) begin dataCyc = cyc; lastData = FrameData; end
        if (done) begin doneCnt++; doneCyc = cyc; end
    end

    int gapPct = 0;
    bit randClr = 0;

    task automatic sendWord(input logic [31:0] w);
        int guard = 0;
        bit acc;
        s_data = w;
        forever begin
            s_valid = ($urandom_range(0, 99) >= gapPct);
            err_clr = randClr && ($urandom_range(0, 15) == 0);
            @(negedge CLK);
            acc = s_valid && s_ready;
            @(posedge CLK); #1;
            err_clr = 1'b0;
            if (acc) break;
            guard++;
            if (guard > 500) begin
                vectors++; miscompares++;
                $display("FAIL accept_timeout: word %0h not accepted within 500 cycles", w);
                break;
            end
        end
    endtask

    task automatic settle();
        int g = 0;
        s_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (!busy) break;
            g++;
            if (g > 300) begin
                vectors++; miscompares++;
                $display("FAIL settle_timeout: busy still %0b after 300 cycles", busy);
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic randPacket();
        int kind, idx, cnt;
        logic [31:0] w, sum;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin w = $urandom; if (w == SYNC) w = '0; sendWord(w); end
        sendWord(SYNC);
        if (kind >= 7) begin idx = $urandom_range(0, 24); cnt = $urandom_range(0, 5); end
        else begin cnt = $urandom_range(1, 6); idx = $urandom_range(0, NF - cnt); end
        w = $urandom;
        w[7:0]  = 8'(idx);
        w[15:8] = 8'(cnt);
        sendWord(w);
        if (cnt != 0 && idx < NF && idx + cnt <= NF) begin
            sum = '0;
            for (int k = 0; k < cnt; k++) begin
                w = ($urandom_range(0, 7) == 0) ? SYNC : $urandom;
                sum = sum + w;
                sendWord(w);
            end
`ifdef CONFIG_CHECKSUM_EN
            sendWord(($urandom_range(0, 3) == 0) ? sum + 32'd1 : sum);
`endif
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, d0, c0;
        repeat (3) @(negedge CLK);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_strobe", 64'(FrameStrobe), 64'd0);
        chk("rst_data", 64'(FrameData), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        #2 resetn = 1'b1;
        @(negedge CLK);
        chk("ready_after_reset", 64'(s_ready), 64'd1);
        @(posedge CLK); #1;

        // single frame at index 0
        n0 = strobeLog.size(); d0 = doneCnt;
        sendWord(SYNC); sendWord(32'h0000_0100); sendWord(32'hDEAD_BEEF);
`ifdef CONFIG_CHECKSUM_EN
        sendWord(32'hDEAD_BEEF);
`endif
        settle();
        chk("t1_nstrobe", 64'(strobeLog.size() - n0), 64'd1);
        if (strobeLog.size() > n0) begin
            chk("t1_mask", 64'(strobeLog[n0].m), 64'h1);
            chk("t1_data", 64'(strobeLog[n0].d), 64'hDEAD_BEEF);
            chk("t1_setup_gap", 64'(strobeLog[n0].c - dataCyc), 64'd1);
`ifndef CONFIG_CHECKSUM_EN
            chk("t1_done_cycle", 64'(doneCyc - strobeLog[n0].c), 64'd2);
`endif
        end
        chk("t1_hold_data", 64'(FrameData), 64'hDEAD_BEEF);
        chk("t1_done_count", 64'(doneCnt - d0), 64'd1);

        // two frames at the top of the column, s_valid held high
        gapPct = 0;
        n0 = strobeLog.size();
        sendWord(SYNC); sendWord(32'h0000_0212); sendWord(32'h1); sendWord(32'h2);
`ifdef CONFIG_CHECKSUM_EN
        sendWord(32'h3);
`endif
        settle();
        chk("t2_nstrobe", 64'(strobeLog.size() - n0), 64'd2);
        if (strobeLog.size() > n0 + 1) begin
            c0 = strobeLog[n0].c;
            chk("t2_mask0", 64'(strobeLog[n0].m), 64'h40000);
            chk("t2_data0", 64'(strobeLog[n0].d), 64'h1);
            chk("t2_mask1", 64'(strobeLog[n0+1].m), 64'h80000);
            chk("t2_data1", 64'(strobeLog[n0+1].d), 64'h2);
            chk("t2_spacing", 64'(strobeLog[n0+1].c - c0), 64'd4);
            chk("t2_ready_dwait", 64'(readyLog[c0-2]), 64'd1);
            chk("t2_ready_setup", 64'(readyLog[c0-1]), 64'd0);
            chk("t2_ready_strobe", 64'(readyLog[c0]), 64'd0);
            chk("t2_ready_hold", 64'(readyLog[c0+1]), 64'd0);
            chk("t2_ready_next", 64'(readyLog[c0+2]), 64'd1);
        end

        // overflowing header, zero-count header, then error clear
        n0 = strobeLog.size(); d0 = doneCnt;
        sendWord(SYNC); sendWord(32'h0000_0213);
        settle();
        chk("t3_err_set", 64'(err), 64'd1);
        chk("t3_no_strobe", 64'(strobeLog.size() - n0), 64'd0);
        sendWord(SYNC); sendWord(32'hABCD_0005);
        settle();
        chk("t3_err_kept", 64'(err), 64'd1);
        chk("t3_no_done", 64'(doneCnt - d0), 64'd0);
        chk("t3_idle", 64'(busy), 64'd0);
        err_clr = 1'b1;
        @(posedge CLK); #1;
        err_clr = 1'b0;
        @(negedge CLK);
        chk("t3_err_cleared", 64'(err), 64'd0);
        @(posedge CLK); #1;

        // garbage before sync, then a three-frame packet with stalls
        sendWord(32'h1234_5678); sendWord(32'hFAB0_FAB0);
        @(negedge CLK);
        chk("t4_garbage_idle", 64'(busy), 64'd0);
        @(posedge CLK); #1;
        gapPct = 40;
        n0 = strobeLog.size();
        sendWord(SYNC); sendWord(32'h0000_0305);
        sendWord(32'hA); sendWord(32'hB); sendWord(32'hC);
`ifdef CONFIG_CHECKSUM_EN
        sendWord(32'h21);
`endif
        settle();
        chk("t4_nstrobe", 64'(strobeLog.size() - n0), 64'd3);
        if (strobeLog.size() > n0 + 2) begin
            chk("t4_mask2", 64'(strobeLog[n0+2].m), 64'h80);
            chk("t4_data2", 64'(strobeLog[n0+2].d), 64'hC);
        end

        // asynchronous reset while a strobe is high
        gapPct = 0;
        d0 = doneCnt;
        sendWord(SYNC); sendWord(32'h0000_0300);
        s_data = 32'h5555_AAAA; s_valid = 1'b1;
        for (int g = 0; g < 50; g++) begin
            @(negedge CLK);
            if (FrameStrobe != '0) break;
        end
        #2 resetn = 1'b0; s_valid = 1'b0;
        #1;
        chk("t5_strobe_async", 64'(FrameStrobe), 64'd0);
        chk("t5_busy_async", 64'(busy), 64'd0);
        chk("t5_done_async", 64'(done), 64'd0);
        @(negedge CLK); @(negedge CLK);
        #2 resetn = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        chk("t5_no_done", 64'(doneCnt - d0), 64'd0);
        n0 = strobeLog.size();
        sendWord(SYNC); sendWord(32'h0000_020A); sendWord(32'h77); sendWord(32'h88);
`ifdef CONFIG_CHECKSUM_EN
        sendWord(32'hFF);
`endif
        settle();
        chk("t5_recover_done", 64'(doneCnt - d0), 64'd1);
        chk("t5_recover_nstrobe", 64'(strobeLog.size() - n0), 64'd2);

`ifdef CONFIG_CHECKSUM_EN
        // wrapping checksum: good trailer then bad trailer
        d0 = doneCnt;
        sendWord(SYNC); sendWord(32'h0000_0200); sendWord(32'hFFFF_FFFF); sendWord(32'h2); sendWord(32'h1);
        settle();
        chk("t6_good_done", 64'(doneCnt - d0), 64'd1);
        chk("t6_good_err", 64'(err), 64'd0);
        d0 = doneCnt;
        sendWord(SYNC); sendWord(32'h0000_0200); sendWord(32'hFFFF_FFFF); sendWord(32'h2); sendWord(32'h2);
        settle();
        chk("t6_bad_done", 64'(doneCnt - d0), 64'd0);
        chk("t6_bad_err", 64'(err), 64'd1);
`endif

        // randomized packets with stalls and stray error clears
        gapPct = 30;
        randClr = 1;
        repeat (120) randPacket();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
